// File: rtl/fft_bitrev_reorder.sv
// Reorders bit-reversed FFT output frames into natural order with first/last framing.
// A two-bank ping-pong buffer lets one frame be written while the other is read out.
module fft_bitrev_reorder #(
  parameter int LOG2N = 7,
  parameter int W     = 32
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         in_start,
  input  logic         in_over,
  input  logic [W-1:0] in_real,
  input  logic [W-1:0] in_img,
  output logic         out_valid,
  output logic         out_first,
  output logic         out_last,
  output logic [W-1:0] out_real,
  output logic [W-1:0] out_img,
  output logic         frame_err
);

  localparam int N = 1 << LOG2N;
  localparam logic [LOG2N-1:0] LAST = LOG2N'(N - 1);
  localparam logic [LOG2N-1:0] ONE  = LOG2N'(1);

  typedef enum logic {W_IDLE, W_WRITE} wr_state_t;
  typedef enum logic {R_IDLE, R_READ}  rd_state_t;

  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] a);
    logic [LOG2N-1:0] r;
    for (int i = 0; i < LOG2N; i++) r[i] = a[LOG2N-1-i];
    return r;
  endfunction

  wr_state_t        wr_state, wr_state_n;
  rd_state_t        rd_state, rd_state_n;
  logic [LOG2N-1:0] wr_cnt, wr_cnt_n, cur_cnt, waddr;
  logic [LOG2N-1:0] rd_cnt, rd_cnt_n;
  logic             wr_bank, wr_bank_n, rd_bank, rd_bank_n;
  logic [1:0]       full, set_full, clr_full;
  logic             we, accept, err_n, rd_en, data_ok;
  logic [2*W-1:0]   mem [2*N];
  logic [2*W-1:0]   rd_q;

  // Write side: sample at in-frame position cnt lands at natural address bitrev(cnt).
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    wr_state_n = wr_state;
    wr_cnt_n   = wr_cnt;
    wr_bank_n  = wr_bank;
    set_full   = 2'b00;
    err_n      = 1'b0;
    accept     = 1'b0;
    we         = 1'b0;
    cur_cnt    = wr_cnt;
    if (in_start) begin
      cur_cnt = '0;
      if (wr_state == W_WRITE) begin
        accept = 1'b1;
        err_n  = 1'b1;
      end else if (full[wr_bank]) begin
        err_n = 1'b1;
      end else begin
        accept = 1'b1;
      end
    end else begin
      accept = (wr_state == W_WRITE);
    end
    waddr = bitrev(cur_cnt);
    if (accept) begin
      we = 1'b1;
      if (cur_cnt == LAST) begin
        wr_state_n = W_IDLE;
        wr_cnt_n   = '0;
        if (in_over) begin
          set_full[wr_bank] = 1'b1;
          wr_bank_n         = ~wr_bank;
        end else begin
          err_n = 1'b1;
        end
      end else if (in_over) begin
        wr_state_n = W_IDLE;
        wr_cnt_n   = '0;
        err_n      = 1'b1;
      end else begin
        wr_state_n = W_WRITE;
        wr_cnt_n   = cur_cnt + ONE;
      end
    end
  end

  // Read side: an idle reader starts issuing address 0 in the same cycle a bank turns full.
  always_comb begin
    rd_state_n = rd_state;
    rd_cnt_n   = rd_cnt;
    rd_bank_n  = rd_bank;
    clr_full   = 2'b00;
    rd_en      = (rd_state == R_READ) || full[rd_bank];
    if (rd_en) begin
      if (rd_cnt == LAST) begin
        clr_full[rd_bank] = 1'b1;
        rd_bank_n         = ~rd_bank;
        rd_cnt_n          = '0;
        rd_state_n        = full[~rd_bank] ? R_READ : R_IDLE;
      end else begin
        rd_cnt_n   = rd_cnt + ONE;
        rd_state_n = R_READ;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_state  <= W_IDLE;
      rd_state  <= R_IDLE;
      wr_cnt    <= '0;
      rd_cnt    <= '0;
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b0;
      full      <= 2'b00;
      out_valid <= 1'b0;
      out_first <= 1'b0;
      out_last  <= 1'b0;
      frame_err <= 1'b0;
      data_ok   <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      wr_state  <= wr_state_n;
      rd_state  <= rd_state_n;
      wr_cnt    <= wr_cnt_n;
      rd_cnt    <= rd_cnt_n;
      wr_bank   <= wr_bank_n;
      rd_bank   <= rd_bank_n;
      full      <= (full & ~clr_full) | set_full;
      out_valid <= rd_en;
      out_first <= rd_en && (rd_cnt == '0);
      out_last  <= rd_en && (rd_cnt == LAST);
      frame_err <= err_n;
      if (rd_en) data_ok <= 1'b1;
    end
  end

  // NOTE: the buffer and its read register carry no reset so they map onto block RAM.
  always_ff @(posedge clk) begin
    if (we) mem[{wr_bank, waddr}] <= {in_real, in_img};
  end

  always_ff @(posedge clk) begin
    if (rd_en) rd_q <= mem[{rd_bank, rd_cnt}];
  end

  // Data is forced to zero until the first read after reset; afterwards it holds between frames.
  assign out_real = data_ok ? rd_q[2*W-1:W] : '0;
  assign out_img  = data_ok ? rd_q[W-1:0]   : '0;

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Self-checking bench for fft_bitrev_reorder: random frames sent in bit-reversed order
// are compared against a queue of natural-order samples built from the same frames.
module tb_fft_bitrev_reorder;

  localparam int LOG2N = 7;
  localparam int N     = 1 << LOG2N;
  localparam int W     = 32;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic         in_start = 1'b0, in_over = 1'b0;
  logic [W-1:0] in_real = '0, in_img = '0;
  logic         out_valid, out_first, out_last, frame_err;
  logic [W-1:0] out_real, out_img;

  fft_bitrev_reorder #(.LOG2N(LOG2N), .W(W)) dut (
    .clk(clk), .rstn(rstn),
    .in_start(in_start), .in_over(in_over), .in_real(in_real), .in_img(in_img),
    .out_valid(out_valid), .out_first(out_first), .out_last(out_last),
    .out_real(out_real), .out_img(out_img), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int err_cnt = 0;
  int run = 0;
  int last_run = 0;
  int out_idx = 0;
  int over_cyc = 0;
  logic [W-1:0] last_re = '0, last_im = '0;
  logic [W-1:0] nat_re [N];
  logic [W-1:0] nat_im [N];
  logic [2*W+1:0] exp_q [$];

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic int rev(input int x);
    int r = 0;
    int v = x;
    for (int i = 0; i < LOG2N; i++) begin
      r = r * 2 + (v % 2);
      v = v / 2;
    end
    return r;
  endfunction

  // Output monitor: every valid sample must match the head of the expected queue.
  always @(negedge clk) begin
    if (!rstn) begin
      run = 0;
      last_re = '0;
      last_im = '0;
    end else begin
      if (frame_err) err_cnt++;
      if (out_valid) begin
        run++;
        out_idx = out_first ? 0 : out_idx + 1;
        if (exp_q.size() == 0) check("spurious_valid", out_valid, 1'b0);
        else check("sample", {out_first, out_last, out_real, out_img}, exp_q.pop_front());
        last_re = out_real;
        last_im = out_img;
      end else begin
        if (run != 0) last_run = run;
        run = 0;
        check("idle_marks", {out_first, out_last}, 2'b00);
        check("idle_hold", {out_real, out_img}, {last_re, last_im});
      end
    end
  end

  task automatic tick(input logic st, input logic ov, input logic [W-1:0] re, input logic [W-1:0] im);
    in_start = st;
    in_over  = ov;
    in_real  = re;
    in_img   = im;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, $urandom, $urandom);
  endtask

  task automatic fill_random();
    for (int k = 0; k < N; k++) begin
      nat_re[k] = $urandom;
      nat_im[k] = $urandom;
    end
  endtask

  // Sends nat_* in bit-reversed order and queues the natural-order result.
  task automatic send_frame();
    for (int k = 0; k < N; k++)
      exp_q.push_back({(k == 0), (k == N - 1), nat_re[k], nat_im[k]});
    for (int c = 0; c < N; c++) begin
      if (c == N - 1) over_cyc = cyc;
      tick((c == 0), (c == N - 1), nat_re[rev(c)], nat_im[rev(c)]);
    end
    in_start = 1'b0;
    in_over  = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      #1;
      if (exp_q.size() == 0 && !out_valid) break;
    end
    check("drain_empty", exp_q.size(), 0);
  endtask

  int e0;
  bit seen;

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_outs", {out_valid, out_first, out_last, frame_err, out_real, out_img}, '0);
    rstn = 1'b1;
    idle(6);

    // Single counting frame: natural sample k carries the position at which it was sent
    for (int c = 0; c < N; c++) begin
      nat_re[rev(c)] = c;
      nat_im[rev(c)] = ~(W'(c));
    end
    send_frame();
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_first) begin
        seen = 1;
        break;
      end
    end
    check("first_seen", seen, 1'b1);
    check("latency", cyc, over_cyc + 2);
    drain();

    // Random single frame with a gap afterwards
    fill_random();
    send_frame();
    idle(5);
    drain();

    // Three back-to-back random frames
    for (int f = 0; f < 3; f++) begin
      fill_random();
      send_frame();
    end
    drain();
    check("b2b_run", last_run, 3 * N);

    // Short frame: in_over at cnt 50, then a good frame
    e0 = err_cnt;
    for (int c = 0; c <= 50; c++) tick((c == 0), (c == 50), $urandom, $urandom);
    idle(4);
    check("short_err", err_cnt - e0, 1);
    check("short_no_out", out_valid, 1'b0);
    fill_random();
    send_frame();
    drain();

    // Long frame: N samples with no in_over
    e0 = err_cnt;
    for (int c = 0; c < N; c++) tick((c == 0), 1'b0, $urandom, $urandom);
    idle(4);
    check("long_err", err_cnt - e0, 1);
    fill_random();
    send_frame();
    drain();

    // Restart: second in_start at cnt 70
    e0 = err_cnt;
    for (int c = 0; c < 70; c++) tick((c == 0), 1'b0, $urandom, $urandom);
    fill_random();
    send_frame();
    drain();
    check("restart_err", err_cnt - e0, 1);

    // Reset during read at output sample 40
    fill_random();
    send_frame();
    seen = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      #1;
      if (out_valid && out_idx == 40) begin
        seen = 1;
        break;
      end
    end
    check("reached_40", seen, 1'b1);
    rstn = 1'b0;
    exp_q.delete();
    #1;
    check("async_reset_outs", {out_valid, out_first, out_last, frame_err, out_real, out_img}, '0);
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    idle(8);
    check("post_reset_idle", out_valid, 1'b0);
    fill_random();
    send_frame();
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fft_bitrev_reorder.md
Name: fft_bitrev_reorder

Overview:
Output-end consumer of the SDF FFT stage chain. It accepts one framed stream of N complex samples in bit-reversed order, using the last stage's start/over framing and 32-bit real/img data. It re-emits each frame in natural order with its own first/last framing. A two-bank ping-pong buffer lets one frame be written while the previous one is read, so back-to-back frames stream with no gaps.

Parameters:
LOG2N, 7, log2 of frame length; N = 1<<LOG2N = 128.
W, 32, width of each of the real and img components.

Ports:
clk  input  1  system clock, all logic on rising edge.
rstn  input  1  asynchronous active-low reset.
in_start  input  1  pulse with sample 0 of an input frame.
in_over  input  1  pulse with sample N-1 of an input frame.
in_real  input  W  input real part, sampled every cycle from in_start through in_over inclusive.
in_img  input  W  input img part, same timing as in_real.
out_valid  output  1  out_real/out_img carry a valid sample.
out_first  output  1  high with natural-order sample 0.
out_last  output  1  high with natural-order sample N-1.
out_real  output  W  output real part.
out_img  output  W  output img part.
frame_err  output  1  one-cycle pulse when an input frame is dropped.

Behaviour:
- Reset (rstn low, async): all outputs 0; both bank-full flags 0; write and read FSMs go to IDLE; write and read counters 0; write bank pointer = bank 0. Memory contents are don't-care.
- Storage: 2 banks x N entries x 2W bits. Read is synchronous with 1-cycle latency (RAM-inferable).
- Write FSM, IDLE -> WRITE:
  - Transition on in_start when the target bank is not full.
  - Sample 0 is written in the in_start cycle; cnt goes 1.
  - In WRITE, one sample per cycle is written at address bitrev(cnt) in the target bank, and cnt increments.
- Write completion:
  - in_over high with cnt==N-1: write the sample, set the bank full flag, toggle the write bank pointer, return to IDLE.
  - in_over with cnt<N-1: short frame. Drop it (bank not marked full), pulse frame_err, go to IDLE.
  - cnt==N-1 without in_over: long frame. Drop it, pulse frame_err, go to IDLE, ignore inputs until the next in_start.
  - in_start while in WRITE: restart the current frame at cnt 0 in the same bank and pulse frame_err.
  - in_start while the target bank is full: ignore the frame, pulse frame_err, stay IDLE.
  - in_start and in_over in the same cycle: valid only if N==1; otherwise treated as a short frame.
- Read FSM, IDLE -> READ: transition when the read bank's full flag is 1. rd_addr runs sequentially 0..N-1, one per cycle.
- Read completion and output timing:
  - On issuing address N-1: clear the full flag, toggle the read bank, and go to IDLE. Go directly to READ if the other bank is already full, giving gapless output.
  - Outputs are registered and appear 1 cycle after the address is issued.
  - out_first goes with address 0, out_last with address N-1. out_valid stays high for exactly N consecutive cycles per frame.
  - Between frames out_valid=0 and out_first=out_last=0; out_real/out_img hold their last value.
- Latency: a frame whose in_over is at cycle T has out_first at T+2 when the read side is idle.
- Throughput: 1 sample/cycle sustained. Back-to-back input frames cannot overflow. A bank set full in the cycle its flag is cleared (same bank) cannot occur with a two-bank pointer scheme. The clear/set of different flags in one cycle are independent.
- Reset mid-frame: partial write discarded, any read in progress aborted immediately, outputs forced to 0.

Test Plan:
- Reset: assert rstn=0 mid-stream -> all outputs 0 same cycle (async); after release no out_valid until a complete frame is written.
- Single frame: in_real=cnt, in_img=~cnt, cnt=0..127, in_over at T -> out_first at T+2 with out_real=0; next samples 64, 32, 96, ...; j=127 -> out_real=127 with out_last; out_img = ~out_real throughout.
- Back-to-back frames: 3 frames, next in_start the cycle after in_over -> 384 contiguous out_valid cycles; out_first at offsets 0, 128, 256; out_last at 127, 255, 383; no data mixing between frames.
- Short frame: in_over at cnt=50 -> frame_err 1 cycle, no out_valid; following good frame is output correctly.
- Restart: second in_start at cnt=70 -> frame_err pulse; frame counted from the new start is output with correct bit-reversed values.
- Reset during read: rstn low at output sample 40 -> out_valid=0 immediately; a new full frame after reset outputs from sample 0.
